// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display arbiter: digit count,
// blank code, FSM state encoding and the BCD segment decoder.
package seg_pkg;

    localparam int         DIGITS     = 8;
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SHOW = 2'd2
    } disp_state_t;

    // Segment order {a,b,c,d,e,f,g}, active-high; codes above 9 are blank.
    function automatic logic [6:0] bcd_to_seven(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b111_1110;
            4'd1:    seg = 7'b011_0000;
            4'd2:    seg = 7'b110_1101;
            4'd3:    seg = 7'b111_1001;
            4'd4:    seg = 7'b011_0011;
            4'd5:    seg = 7'b101_1011;
            4'd6:    seg = 7'b101_1111;
            4'd7:    seg = 7'b111_0000;
            4'd8:    seg = 7'b111_1111;
            4'd9:    seg = 7'b111_1011;
            default: seg = 7'b000_0000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan.sv
// Free-running digit scanner: walks the 8 digits, decodes the selected one
// and registers the active-low cathode/anode drive, blanking on request.
module seg_scan
    import seg_pkg::*;
(
    input  logic                iclk,
    input  logic                nrst,
    input  logic                blank,
    input  logic [DIGITS*4-1:0] digits,
    input  logic [DIGITS-1:0]   dots,
    output logic                frame_tick,
    output logic [7:0]          cathodes,
    output logic [7:0]          anodes
);

    logic [2:0] addr_q, addr_d;
    logic [7:0] cathodes_q, cathodes_d;
    logic [7:0] anodes_q, anodes_d;
    logic [3:0] cur_digit;

    always_comb begin
        addr_d    = addr_q + 3'd1;
        cur_digit = digits[{addr_q, 2'b00} +: 4];
        if (blank) begin
            cathodes_d = 8'hFF;
            anodes_d   = 8'hFF;
        end else begin
            cathodes_d = ~{bcd_to_seven(cur_digit), dots[addr_q]};
            anodes_d   = ~(8'b1000_0000 >> addr_q);
        end
    end

    always_ff @(posedge iclk or negedge nrst) begin
        if (!nrst) begin
            addr_q     <= 3'd0;
            cathodes_q <= 8'hFF;
            anodes_q   <= 8'hFF;
        end else begin
            addr_q     <= addr_d;
            cathodes_q <= cathodes_d;
            anodes_q   <= anodes_d;
        end
    end

    assign frame_tick = (addr_q == 3'd7);
    assign cathodes   = cathodes_q;
    assign anodes     = anodes_q;

endmodule

// File: rtl/seg_display_arbiter.sv
// Round-robin owner of the shared 8-digit display: grants one requester at a
// time with minimum/maximum hold, latches its frame and feeds the scanner.
module seg_display_arbiter
    import seg_pkg::*;
#(
    parameter int NREQ     = 3,
    parameter int MIN_HOLD = 2,
    parameter int MAX_HOLD = 16
) (
    input  logic                iclk,
    input  logic                nrst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*32-1:0]  req_digits,
    input  logic [NREQ*8-1:0]   req_dots,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic [7:0]          cathodes,
    output logic [7:0]          anodes
);

    localparam int              PW     = $clog2(NREQ);
    localparam int              HW     = $clog2(MAX_HOLD + 1);
    localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
    localparam logic [HW-1:0]   MIN_W  = HW'(MIN_HOLD);
    localparam logic [HW-1:0]   MAX_W  = HW'(MAX_HOLD);

    disp_state_t          state_q, state_d;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 busy_q, busy_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [DIGITS*4-1:0]  buf_q, buf_d;
    logic [DIGITS-1:0]    dot_q, dot_d;

    logic [PW:0]          scan_idx;
    logic [PW-1:0]        winner;
    logic                 found;
    logic [PW:0]          ptr_inc;
    logic                 owner_req;
    logic                 other_req;
    logic                 exit_now;
    logic                 frame_tick;
    logic [31:0]          owner_digits;
    logic [7:0]           owner_dots;

    // First requester at or above rr_ptr, wrapping at NREQ rather than 2**PW.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!found && req[scan_idx[PW-1:0]]) begin
                found  = 1'b1;
                winner = scan_idx[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_inc      = {1'b0, owner_q} + (PW+1)'(1);
        owner_req    = req[owner_q];
        other_req    = |(req & ~gnt_q);
        owner_digits = req_digits[{owner_q, 5'b0_0000} +: 32];
        owner_dots   = req_dots[{owner_q, 3'b000} +: 8];
        exit_now     = (!owner_req && (hold_cnt_q >= MIN_W)) ||
                       ((hold_cnt_q == MAX_W) && other_req);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        busy_d     = busy_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        buf_d      = buf_q;
        dot_d      = dot_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOAD;
                    gnt_d   = NREQ'(1) << winner;
                    busy_d  = 1'b1;
                    owner_d = winner;
                end
            end
            LOAD: begin
                buf_d      = owner_digits;
                dot_d      = owner_dots;
                hold_cnt_d = '0;
                rr_ptr_d   = (ptr_inc >= NREQ_W) ? '0 : ptr_inc[PW-1:0];
                state_d    = SHOW;
            end
            SHOW: begin
                // An exit wins over a coinciding frame tick: no re-latch.
                if (exit_now) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                end else if (frame_tick) begin
                    buf_d = owner_digits;
                    dot_d = owner_dots;
                    if (hold_cnt_q != MAX_W) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            buf_q      <= {DIGITS{BLANK_CODE}};
            dot_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            buf_q      <= buf_d;
            dot_q      <= dot_d;
        end
    end

    seg_scan u_scan (
        .iclk       (iclk),
        .nrst       (nrst),
        .blank      (state_q != SHOW),
        .digits     (buf_q),
        .dots       (dot_q),
        .frame_tick (frame_tick),
        .cathodes   (cathodes),
        .anodes     (anodes)
    );

    assign gnt  = gnt_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Scoreboard bench for seg_display_arbiter: grant changes and displayed
// digits are checked by a monitor against queues filled by the stimulus.
module tb_seg_display_arbiter;

    localparam int NREQ = 3;

    logic                iclk = 1'b0;
    logic                nrst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*32-1:0]  req_digits = '0;
    logic [NREQ*8-1:0]   req_dots = '0;
    logic [NREQ-1:0]     gnt;
    logic                busy;
    logic [7:0]          cathodes;
    logic [7:0]          anodes;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] an;
        logic [7:0] cath;
        string      name;
    } disp_exp_t;

    logic [NREQ-1:0] gnt_exp_q[$];
    disp_exp_t       disp_q[$];

    seg_display_arbiter #(
        .NREQ     (NREQ),
        .MIN_HOLD (2),
        .MAX_HOLD (16)
    ) dut (
        .iclk       (iclk),
        .nrst       (nrst),
        .req        (req),
        .req_digits (req_digits),
        .req_dots   (req_dots),
        .gnt        (gnt),
        .busy       (busy),
        .cathodes   (cathodes),
        .anodes     (anodes)
    );

    always #5 iclk = ~iclk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual, input int lo, input int hi);
        checks++;
        if (actual < lo || actual > hi) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, required %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic [NREQ*32-1:0] d, input logic [NREQ*8-1:0] p);
        req        = r;
        req_digits = d;
        req_dots   = p;
    endtask

    task automatic step();
        @(posedge iclk);
        #1;
    endtask

    task automatic pushDisp(input logic [7:0] an, input logic [7:0] ca, input string nm);
        disp_exp_t e;
        e.an   = an;
        e.cath = ca;
        e.name = nm;
        disp_q.push_back(e);
    endtask

    task automatic waitGnt(input logic [NREQ-1:0] val, input int maxc, input string nm);
        int c = 0;
        while (gnt !== val && c < maxc) begin
            step();
            c++;
        end
        checkOutput(nm, 32'(gnt), 32'(val));
    endtask

    task automatic waitDisp(input int maxc);
        int c = 0;
        while (disp_q.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        checkOutput("disp_queue_drained", 32'(disp_q.size()), 32'd0);
    endtask

    // Monitor: pops an expected grant on every grant change and an expected
    // cathode pattern whenever the head entry's digit is being driven.
    initial begin : monitor
        logic [NREQ-1:0] prev_gnt;
        logic [NREQ-1:0] exp_gnt;
        disp_exp_t       d;
        prev_gnt = '0;
        forever begin
            @(negedge iclk);
            if (gnt !== prev_gnt) begin
                checkOutput("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
                if (gnt_exp_q.size() == 0) begin
                    checkOutput("gnt_unexpected_change", 32'(gnt), 32'(prev_gnt));
                end else begin
                    exp_gnt = gnt_exp_q.pop_front();
                    checkOutput("gnt_sequence", 32'(gnt), 32'(exp_gnt));
                    checkOutput("busy_with_gnt", 32'(busy), 32'(exp_gnt != '0));
                end
                prev_gnt = gnt;
            end
            if (disp_q.size() != 0 && anodes == disp_q[0].an) begin
                d = disp_q.pop_front();
                checkOutput(d.name, 32'(cathodes), 32'(d.cath));
            end
        end
    end

    initial begin : stimulus
        int dur;
        int blanks;
        int c;
        logic [NREQ-1:0] rr_next [3];
        rr_next[0] = 3'b010;
        rr_next[1] = 3'b100;
        rr_next[2] = 3'b001;

        // Reset state
        #2 nrst = 1'b0;
        #1;
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_anodes", 32'(anodes), 32'hFF);
        checkOutput("reset_cathodes", 32'(cathodes), 32'hFF);
        repeat (2) @(posedge iclk);
        @(negedge iclk);
        nrst = 1'b1;
        step();

        // Single requester, digits 1,2,1,1,1,9,6,7 with points on digits 4 and 6
        gnt_exp_q.push_back(3'b001);
        pushDisp(8'h7F, 8'h9F, "t1_digit0");
        pushDisp(8'hBF, 8'h25, "t1_digit1");
        pushDisp(8'hDF, 8'h9F, "t1_digit2");
        pushDisp(8'hEF, 8'h9F, "t1_digit3");
        pushDisp(8'hF7, 8'h9E, "t1_digit4_dp");
        pushDisp(8'hFB, 8'h09, "t1_digit5");
        pushDisp(8'hFD, 8'h40, "t1_digit6_dp");
        pushDisp(8'hFE, 8'h1F, "t1_digit7");
        applyStimulus(3'b001, {32'h0, 32'h0, 32'h7691_1121}, {8'h00, 8'h00, 8'b0101_0000});
        step();
        checkOutput("t1_grant_latency", 32'(gnt), 32'b001);
        checkOutput("t1_blank_at_grant", 32'(anodes), 32'hFF);
        step();
        checkOutput("t1_blank_at_load", 32'(anodes), 32'hFF);
        step();
        checkOutput("t1_first_nonblank", 32'(anodes != 8'hFF), 32'd1);
        waitDisp(40);
        gnt_exp_q.push_back(3'b000);
        applyStimulus(3'b000, req_digits, req_dots);
        waitGnt(3'b000, 40, "t1_release");
        repeat (3) step();

        // Early release: requester 1 drops after one frame, held to MIN_HOLD
        gnt_exp_q.push_back(3'b010);
        gnt_exp_q.push_back(3'b000);
        applyStimulus(3'b010, {32'h0, 32'h8888_8888, 32'h7691_1121}, {8'h00, 8'h00, 8'h50});
        waitGnt(3'b010, 10, "t2_grant");
        repeat (9) step();
        checkOutput("t2_held_after_drop", 32'(gnt), 32'b010);
        applyStimulus(3'b000, req_digits, req_dots);
        dur = 9;
        while (gnt != '0 && dur < 60) begin
            step();
            dur++;
        end
        checkRange("t2_min_hold_cycles", dur, 11, 18);
        repeat (3) step();

        // Live update on digit 3 and an invalid code with point on digit 5
        gnt_exp_q.push_back(3'b100);
        applyStimulus(3'b100, {32'h00A0_1000, 32'h0, 32'h0}, {8'b0010_0000, 8'h00, 8'h00});
        waitGnt(3'b100, 10, "t3_grant");
        c = 0;
        while (anodes !== 8'hBF && c < 30) begin
            step();
            c++;
        end
        checkOutput("t3_saw_digit1", 32'(anodes), 32'hBF);
        applyStimulus(3'b100, {32'h00A0_5000, 32'h0, 32'h0}, {8'b0010_0000, 8'h00, 8'h00});
        pushDisp(8'hEF, 8'h9F, "t3_digit3_before_tick");
        pushDisp(8'hFB, 8'hFE, "t3_invalid_bcd_dot");
        pushDisp(8'hEF, 8'h49, "t3_digit3_after_tick");
        waitDisp(40);
        gnt_exp_q.push_back(3'b000);
        applyStimulus(3'b000, req_digits, req_dots);
        waitGnt(3'b000, 40, "t3_release");
        repeat (3) step();

        // Round-robin with all three requesting: 0 -> 1 -> 2 -> 0
        gnt_exp_q.push_back(3'b001);
        gnt_exp_q.push_back(3'b000);
        gnt_exp_q.push_back(3'b010);
        gnt_exp_q.push_back(3'b000);
        gnt_exp_q.push_back(3'b100);
        gnt_exp_q.push_back(3'b000);
        gnt_exp_q.push_back(3'b001);
        applyStimulus(3'b111, {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}, '0);
        waitGnt(3'b001, 10, "t4_first_owner");
        dur = 0;
        for (int i = 0; i < 3; i++) begin
            while (gnt != '0 && dur < 300) begin
                step();
                dur++;
            end
            checkRange($sformatf("t4_hold_cycles_%0d", i), dur, 123, 130);
            blanks = 0;
            step();
            while (anodes == 8'hFF && blanks < 10) begin
                blanks++;
                step();
            end
            checkOutput($sformatf("t4_handover_blanks_%0d", i), 32'(blanks), 32'd2);
            checkOutput($sformatf("t4_next_owner_%0d", i), 32'(gnt), 32'(rr_next[i]));
            dur = 2;
        end

        // Asynchronous reset in the middle of SHOW
        repeat (20) step();
        #3;
        gnt_exp_q.push_back(3'b000);
        nrst = 1'b0;
        #1;
        checkOutput("t5_async_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        checkOutput("t5_async_anodes", 32'(anodes), 32'hFF);
        checkOutput("t5_async_cathodes", 32'(cathodes), 32'hFF);
        @(posedge iclk);
        #2;
        gnt_exp_q.push_back(3'b001);
        nrst = 1'b1;
        waitGnt(3'b001, 5, "t5_first_winner_after_reset");
        gnt_exp_q.push_back(3'b000);
        applyStimulus(3'b000, req_digits, req_dots);
        waitGnt(3'b000, 40, "t5_release");
        repeat (4) step();

        checkOutput("gnt_queue_drained", 32'(gnt_exp_q.size()), 32'd0);
        checkOutput("disp_queue_empty", 32'(disp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
